seq_pipe: RTL

- Parametrised next-generation instruction sequencer: decodes push/add/mult/send instructions, executes them against an internal register file, and streams register contents to the UART transmitter.
- Generalised in register count, datapath width and immediate width.
- Adds a ready/valid instruction handshake, stall-on-busy UART sends (no dropped sends), multi-byte MSB-first sends, selectable saturating arithmetic, and an overflow pulse.
- Sits between the instruction source and the UART TX block.

---
 rtl/seq_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seq_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_pipe                                                         |
// | Brief   : push/add/mult/send instruction sequencer with a ready/valid      |
// |           instruction port and a stalling, MSB-first multi-byte UART feed. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module seq_pipe #(
    parameter int DP_WIDTH  = 8,
    parameter int ALU_WIDTH = 16,
    parameter int RN_WIDTH  = 2,
    parameter int IM_WIDTH  = 8,
    parameter int SAT       = 0,
    localparam int IN_WIDTH = 2 + ((IM_WIDTH > 3*RN_WIDTH) ? IM_WIDTH : 3*RN_WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] i_inst,
    input  logic                i_inst_valid,
    output logic                o_inst_ready,
    output logic [DP_WIDTH-1:0] o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_busy,
    output logic                o_ovf
);

    localparam int NBYTES = ALU_WIDTH / DP_WIDTH;
    localparam int NREGS  = 2**RN_WIDTH;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [1:0] c_op_push = 2'd0;
    localparam logic [1:0] c_op_add  = 2'd1;
    localparam logic [1:0] c_op_mult = 2'd2;
    localparam logic [1:0] c_op_send = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ALU_WIDTH-1:0]   regs_q [NREGS];
    logic [ALU_WIDTH-1:0]   regs_d [NREGS];
    logic [ALU_WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   ovf_q, ovf_d;

    logic [1:0]             w_op;
    logic [RN_WIDTH-1:0]    w_ra, w_rb, w_rc;
    logic [IM_WIDTH-1:0]    w_imm;
    logic [ALU_WIDTH-1:0]   w_opa, w_opb;
    logic [ALU_WIDTH:0]     w_sum;
    logic [2*ALU_WIDTH-1:0] w_prod;
    logic                   w_prod_ovf;
    logic                   w_accept;

    assign w_op  = i_inst[IN_WIDTH-1:IN_WIDTH-2];
    assign w_rc  = i_inst[RN_WIDTH-1:0];
    assign w_rb  = i_inst[2*RN_WIDTH-1:RN_WIDTH];
    assign w_ra  = i_inst[3*RN_WIDTH-1:2*RN_WIDTH];
    assign w_imm = i_inst[IM_WIDTH-1:0];

    // Operands come from the current register state, so aliasing ra/rb/rc is safe.
    assign w_opa      = regs_q[w_ra];
    assign w_opb      = regs_q[w_rb];
    assign w_sum      = {1'b0, w_opa} + {1'b0, w_opb};
    assign w_prod     = {{ALU_WIDTH{1'b0}}, w_opa} * {{ALU_WIDTH{1'b0}}, w_opb};
    assign w_prod_ovf = |w_prod[2*ALU_WIDTH-1:ALU_WIDTH];
    assign w_accept   = i_inst_valid & ready_q;

    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        c_op_push: regs_d[w_ra] = ALU_WIDTH'(w_imm);
                        c_op_add: begin
                            ovf_d        = w_sum[ALU_WIDTH];
                            regs_d[w_rc] = (w_sum[ALU_WIDTH] && SAT != 0) ? '1
                                                                          : w_sum[ALU_WIDTH-1:0];
                        end
                        c_op_mult: begin
                            ovf_d        = w_prod_ovf;
                            regs_d[w_rc] = (w_prod_ovf && SAT != 0) ? '1
                                                                    : w_prod[ALU_WIDTH-1:0];
                        end
                        c_op_send: begin
                            shreg_d = w_opa;
                            cnt_d   = '0;
                            state_d = ST_SEND;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SEND: begin
                // Zero-fill shifting leaves shreg at 0 once the last byte leaves.
                if (!i_tx_busy) begin
                    shreg_d = shreg_q << DP_WIDTH;
                    if (cnt_q == CNT_W'(NBYTES-1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            regs_q  <= '{default: '0};
            shreg_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_inst_ready = ready_q;
    assign o_tx_valid   = (state_q == ST_SEND);
    assign o_tx_data    = shreg_q[ALU_WIDTH-1 -: DP_WIDTH];
    assign o_ovf        = ovf_q;

endmodule
`default_nettype wire
